// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, line type and arbiter states for the line-cache port arbiter
package cache_pkg;
  localparam int LINE_W   = 644;
  localparam int ADDR_W   = 4;
  localparam int ADDR_LSB = 639;
  localparam int DEPTH    = 2 ** ADDR_W;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } arb_state_t;
endpackage

// File: rtl/cache_rr_arb.sv
// rtl/cache_rr_arb.sv - 2-way round-robin grant (write/read), pointer moves on accept
module cache_rr_arb (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_wr_req,
  input  logic i_rd_req,
  output logic o_wr_gnt,
  output logic o_rd_gnt
);
  logic r_prefer_rd;

  always_comb begin
    o_wr_gnt = 1'b0;
    o_rd_gnt = 1'b0;
    if (i_en) begin
      if (i_wr_req && (!i_rd_req || !r_prefer_rd)) begin
        o_wr_gnt = 1'b1;
      end else if (i_rd_req) begin
        o_rd_gnt = 1'b1;
      end
    end
  end

  // A grant is only issued to a requesting side, so a grant is an accept.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_prefer_rd <= 1'b0;
    end else if (o_wr_gnt) begin
      r_prefer_rd <= 1'b1;
    end else if (o_rd_gnt) begin
      r_prefer_rd <= 1'b0;
    end
  end
endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - shares the single line-cache port between the write and read clients
// and keeps a valid scoreboard so reads of unwritten lines miss without a cache access.
module cache_port_arbiter
  import cache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [LINE_W-1:0] i_wr_line,
  input  logic              i_rd_req_valid,
  output logic              o_rd_req_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_resp_valid,
  input  logic              i_rd_resp_ready,
  output logic [LINE_W-1:0] o_rd_resp_line,
  output logic              o_rd_resp_hit,
  output logic [LINE_W-1:0] o_cache_d,
  output logic [ADDR_W-1:0] o_cache_addr,
  output logic              o_cache_rd,
  input  logic [LINE_W-1:0] i_cache_q,
  output logic              o_busy
);
  arb_state_t r_state;
  arb_state_t w_next;

  logic [DEPTH-1:0]  r_sb;
  logic              r_flush_pend;
  line_t             r_wr_line;
  addr_t             r_rd_addr;
  line_t             r_resp_line;
  logic              r_resp_hit;

  logic              w_flush;
  logic              w_arb_en;
  logic              w_wr_gnt;
  logic              w_rd_gnt;
  addr_t             w_wr_idx;

  assign w_flush  = i_flush | r_flush_pend;
  assign w_arb_en = (r_state == IDLE) && !w_flush;
  assign w_wr_idx = r_wr_line[ADDR_LSB+ADDR_W-1:ADDR_LSB];

  cache_rr_arb u_rr_arb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (w_arb_en),
    .i_wr_req (i_wr_valid),
    .i_rd_req (i_rd_req_valid),
    .o_wr_gnt (w_wr_gnt),
    .o_rd_gnt (w_rd_gnt)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_gnt) begin
          w_next = WRITE;
        end else if (w_rd_gnt) begin
          w_next = r_sb[i_rd_addr] ? RD_ISSUE : RESP;
        end
      end
      WRITE:    w_next = IDLE;
      RD_ISSUE: w_next = RD_WAIT;
      RD_WAIT:  w_next = RESP;
      RESP:     if (i_rd_resp_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    o_wr_ready      = w_wr_gnt;
    o_rd_req_ready  = w_rd_gnt;
    o_rd_resp_valid = (r_state == RESP);
    o_rd_resp_line  = r_resp_line;
    o_rd_resp_hit   = r_resp_hit;
    o_busy          = (r_state != IDLE);
    o_cache_rd      = 1'b1;
    o_cache_d       = '0;
    o_cache_addr    = '0;
    if (r_state == WRITE) begin
      o_cache_rd   = 1'b0;
      o_cache_d    = r_wr_line;
      o_cache_addr = w_wr_idx;
    end else if (r_state == RD_ISSUE) begin
      o_cache_addr = r_rd_addr;
    end
  end

  // A flush seen while busy is remembered and applied on the next idle cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sb         <= '0;
      r_flush_pend <= 1'b0;
      r_wr_line    <= '0;
      r_rd_addr    <= '0;
      r_resp_line  <= '0;
      r_resp_hit   <= 1'b0;
    end else begin
      r_flush_pend <= (r_state != IDLE) && (r_flush_pend || i_flush);
      if ((r_state == IDLE) && w_flush) begin
        r_sb <= '0;
      end else if (r_state == WRITE) begin
        r_sb[w_wr_idx] <= 1'b1;
      end
      if (w_wr_gnt) begin
        r_wr_line <= i_wr_line;
      end
      if (w_rd_gnt) begin
        r_rd_addr   <= i_rd_addr;
        r_resp_line <= '0;
        r_resp_hit  <= 1'b0;
      end
      if (r_state == RD_WAIT) begin
        r_resp_line <= i_cache_q;
        r_resp_hit  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed self-checking bench for cache_port_arbiter with a behavioural cache
module tb_cache_port_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         wr_valid;
  logic         wr_ready;
  logic [643:0] wr_line;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [3:0]   rd_addr;
  logic         rd_resp_valid;
  logic         rd_resp_ready;
  logic [643:0] rd_resp_line;
  logic         rd_resp_hit;
  logic [643:0] cache_d;
  logic [3:0]   cache_addr;
  logic         cache_rd;
  logic [643:0] cache_q;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [643:0] mem [16];
  logic [643:0] line_a;
  logic [643:0] line_5;
  logic [643:0] line_0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cache_rd) mem[cache_addr] <= cache_d;
    else           cache_q <= mem[cache_addr];
  end

  cache_port_arbiter dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_flush         (flush),
    .i_wr_valid      (wr_valid),
    .o_wr_ready      (wr_ready),
    .i_wr_line       (wr_line),
    .i_rd_req_valid  (rd_req_valid),
    .o_rd_req_ready  (rd_req_ready),
    .i_rd_addr       (rd_addr),
    .o_rd_resp_valid (rd_resp_valid),
    .i_rd_resp_ready (rd_resp_ready),
    .o_rd_resp_line  (rd_resp_line),
    .o_rd_resp_hit   (rd_resp_hit),
    .o_cache_d       (cache_d),
    .o_cache_addr    (cache_addr),
    .o_cache_rd      (cache_rd),
    .i_cache_q       (cache_q),
    .o_busy          (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [643:0] line, output bit ok);
    int n;
    ok = 1'b0;
    wr_line = line;
    wr_valid = 1'b1;
    n = 0;
    #1;
    while (!wr_ready && n < 20) begin tick; #1; n++; end
    ok = wr_ready;
    tick;
    wr_valid = 1'b0;
    n = 0;
    #1;
    while (busy && n < 20) begin tick; #1; n++; end
    if (busy) ok = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output bit ok, output logic hit,
                         output logic [643:0] line, output int lat, output bit saw_wr);
    int n;
    rd_addr = a;
    rd_req_valid = 1'b1;
    rd_resp_ready = 1'b1;
    saw_wr = 1'b0;
    n = 0;
    #1;
    while (!rd_req_ready && n < 20) begin tick; #1; n++; end
    ok = rd_req_ready;
    tick;
    rd_req_valid = 1'b0;
    lat = 1;
    #1;
    while (!rd_resp_valid && lat < 20) begin
      if (!cache_rd) saw_wr = 1'b1;
      tick; #1; lat++;
    end
    ok = ok && rd_resp_valid;
    hit = rd_resp_hit;
    line = rd_resp_line;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_req_valid = 1'b0;
    wr_line = '0; rd_addr = '0; rd_resp_ready = 1'b0;
    tick; tick; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cache_rd !== 1'b1) begin errors++; $display("FAIL reset_cache_rd got %b exp 1", cache_rd); end
    checks++; if (cache_d !== '0) begin errors++; $display("FAIL reset_cache_d got %0h exp 0", cache_d); end
    checks++; if (cache_addr !== 4'h0) begin errors++; $display("FAIL reset_cache_addr got %0h exp 0", cache_addr); end
    checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", rd_resp_valid); end
    checks++; if (rd_resp_hit !== 1'b0) begin errors++; $display("FAIL reset_resp_hit got %b exp 0", rd_resp_hit); end
    checks++; if (rd_resp_line !== '0) begin errors++; $display("FAIL reset_resp_line got %0h exp 0", rd_resp_line); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_miss_read;
    bit ok, sw; logic hit; logic [643:0] line; int lat;
    do_read(4'h3, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_handshake got %b exp 1", ok); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", hit); end
    checks++; if (line !== '0) begin errors++; $display("FAIL miss_line got %0h exp 0", line); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL miss_latency got %0d exp 1", lat); end
    checks++; if (sw !== 1'b0) begin errors++; $display("FAIL miss_cache_rd_low got %b exp 0", sw); end
  endtask

  task automatic test_write_read_hit;
    bit ok, sw; logic hit; logic [643:0] line; int lat; int nz;
    wr_line = line_a;
    wr_valid = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", wr_ready); end
    checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL wr_only_rd_ready got %b exp 0", rd_req_ready); end
    tick;
    wr_valid = 1'b0;
    nz = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (!cache_rd) begin
        nz++;
        checks++; if (cache_addr !== 4'hA) begin errors++; $display("FAIL wr_cache_addr got %0h exp a", cache_addr); end
        checks++; if (cache_d !== line_a) begin errors++; $display("FAIL wr_cache_d got %0h exp %0h", cache_d, line_a); end
      end
      tick;
    end
    checks++; if (nz !== 1) begin errors++; $display("FAIL wr_low_cycles got %0d exp 1", nz); end
    do_read(4'hA, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hit_handshake got %b exp 1", ok); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_flag got %b exp 1", hit); end
    checks++; if (line !== line_a) begin errors++; $display("FAIL hit_line got %0h exp %0h", line, line_a); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL hit_latency got %0d exp 3", lat); end
    checks++; if (sw !== 1'b0) begin errors++; $display("FAIL hit_cache_rd_low got %b exp 0", sw); end
  endtask

  task automatic test_resp_stall;
    int n;
    rd_addr = 4'hA;
    rd_req_valid = 1'b1;
    rd_resp_ready = 1'b0;
    #1;
    checks++; if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL stall_accept got %b exp 1", rd_req_ready); end
    tick;
    rd_req_valid = 1'b0;
    n = 0;
    #1;
    while (!rd_resp_valid && n < 20) begin tick; #1; n++; end
    wr_line = line_5; wr_valid = 1'b1;
    rd_addr = 4'h3; rd_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rd_resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %b exp 1", i, rd_resp_valid); end
      checks++; if (rd_resp_hit !== 1'b1 || rd_resp_line !== line_a) begin errors++; $display("FAIL stall_data c%0d got hit %b line %0h exp hit 1 line %0h", i, rd_resp_hit, rd_resp_line, line_a); end
      checks++; if ((wr_ready | rd_req_ready) !== 1'b0) begin errors++; $display("FAIL stall_accept_blocked c%0d got %b%b exp 00", i, wr_ready, rd_req_ready); end
      tick;
    end
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    rd_resp_ready = 1'b1;
    tick;
    #1;
    checks++; if (busy !== 1'b0 || rd_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got busy %b valid %b exp 0 0", busy, rd_resp_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] ord; int grants; bit both; int n;
    ord = '0; grants = 0; both = 1'b0; n = 0;
    wr_line = line_5; wr_valid = 1'b1;
    rd_addr = 4'h5; rd_req_valid = 1'b1; rd_resp_ready = 1'b1;
    while (grants < 4 && n < 60) begin
      #1;
      if (wr_ready && rd_req_ready) both = 1'b1;
      if (wr_ready) begin ord = {ord[2:0], 1'b1}; grants++; end
      else if (rd_req_ready) begin ord = {ord[2:0], 1'b0}; grants++; end
      tick;
      n++;
    end
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    n = 0;
    #1;
    while (busy && n < 20) begin tick; #1; n++; end
    checks++; if (grants !== 4) begin errors++; $display("FAIL rr_grant_count got %0d exp 4", grants); end
    checks++; if (ord !== 4'b1010) begin errors++; $display("FAIL rr_order got %b exp 1010 (1=W)", ord); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_both_ready got %b exp 0", both); end
    tick;
  endtask

  task automatic test_reset_mid_wait;
    bit ok, sw; logic hit; logic [643:0] line; int lat;
    rd_addr = 4'hA; rd_req_valid = 1'b1; rd_resp_ready = 1'b1;
    #1;
    tick;
    rd_req_valid = 1'b0;
    tick;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", rd_resp_valid); end
    checks++; if (cache_rd !== 1'b1) begin errors++; $display("FAIL rst_mid_cache_rd got %b exp 1", cache_rd); end
    tick;
    rst_n = 1'b1;
    tick;
    do_read(4'hA, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1 || hit !== 1'b0 || lat !== 1) begin errors++; $display("FAIL rst_sb_a got ok %b hit %b lat %0d exp 1 0 1", ok, hit, lat); end
    do_read(4'h5, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1 || hit !== 1'b0 || line !== '0) begin errors++; $display("FAIL rst_sb_5 got ok %b hit %b line %0h exp 1 0 0", ok, hit, line); end
  endtask

  task automatic test_flush;
    bit ok, sw; logic hit; logic [643:0] line; int lat;
    do_write(line_0, ok);
    do_read(4'h0, ok, hit, line, lat, sw);
    checks++; if (hit !== 1'b1 || line !== line_0) begin errors++; $display("FAIL flush_pre got hit %b line %0h exp 1 %0h", hit, line, line_0); end
    flush = 1'b1;
    rd_addr = 4'h0; rd_req_valid = 1'b1;
    #1;
    checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready got %b exp 0", rd_req_ready); end
    tick;
    flush = 1'b0;
    do_read(4'h0, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1 || hit !== 1'b0 || line !== '0) begin errors++; $display("FAIL flush_read got ok %b hit %b line %0h exp 1 0 0", ok, hit, line); end
    do_write('0, ok);
    do_read(4'h0, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1 || hit !== 1'b1 || line !== '0 || lat !== 3) begin errors++; $display("FAIL zero_line got ok %b hit %b line %0h lat %0d exp 1 1 0 3", ok, hit, line, lat); end
    wr_line = line_0; wr_valid = 1'b1;
    #1;
    tick;
    wr_valid = 1'b0;
    flush = 1'b1;
    rd_addr = 4'h0; rd_req_valid = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL pend_flush_ready got %b exp 0", rd_req_ready); end
    do_read(4'h0, ok, hit, line, lat, sw);
    checks++; if (ok !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL pend_flush_read got ok %b hit %b exp 1 0", ok, hit); end
  endtask

  initial begin
    line_a = {4'hD, {159{4'h5}}, 4'h6};
    line_5 = {4'h2, 4'h8, 636'h5A5};
    line_0 = 644'h1234;
    test_reset;
    test_miss_read;
    test_write_read_hit;
    test_resp_stall;
    test_round_robin;
    test_reset_mid_wait;
    test_flush;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
